// File: rtl/im_boot_loader_if.sv
// Host-side load control, byte stream and instruction-memory write port of the boot loader.
// The master modport is the host/bench side; the slave modport is the loader itself.
interface im_boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              load_abort;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   words_loaded;
  logic [7:0]        checksum;

  modport master (
    output load_start, load_len, load_abort, byte_valid, byte_data,
    input  byte_ready, im_we, im_waddr, im_wdata, cpu_rst_n, busy, done,
           words_loaded, checksum
  );

  modport slave (
    input  load_start, load_len, load_abort, byte_valid, byte_data,
    output byte_ready, im_we, im_waddr, im_wdata, cpu_rst_n, busy, done,
           words_loaded, checksum
  );
endinterface

// File: rtl/im_boot_loader.sv
// Loads a big-endian byte stream into instruction memory word by word and
// holds the CPU in reset until the requested number of words has been written.
module im_boot_loader #(
  parameter int ADDR_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  im_boot_loader_if.slave bus
);
  typedef enum logic [1:0] {BOOT_WAIT, LOAD, RELEASE, RUN} state_t;

  localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [ADDR_W:0]   target_q, target_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_waddr_q, im_waddr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
  logic [7:0]        checksum_q, checksum_d;
  logic              byte_ready;
  logic              accept;
  logic              start_load;

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    shift_d        = shift_q;
    target_d       = target_q;
    im_we_d        = 1'b0;
    im_waddr_d     = im_waddr_q;
    im_wdata_d     = im_wdata_q;
    cpu_rst_n_d    = cpu_rst_n_q;
    done_d         = 1'b0;
    words_loaded_d = words_loaded_q;
    checksum_d     = checksum_q;

    byte_ready = (state_q == LOAD) && !bus.load_abort;
    accept     = byte_ready && bus.byte_valid;
    start_load = bus.load_start && (bus.load_len != '0) &&
                 ((state_q == BOOT_WAIT) || (state_q == RUN));

    // Write cycle ends: count it, and step the address unless that was the last slot.
    if (im_we_q) begin
      words_loaded_d = words_loaded_q + ONE_WORD;
      if ((words_loaded_q + ONE_WORD) < target_q)
        im_waddr_d = words_loaded_q[ADDR_W-1:0] + ONE_ADDR;
    end

    case (state_q)
      BOOT_WAIT, RUN: begin
        if (bus.load_start && (bus.load_len == '0)) begin
          state_d     = RUN;
          cpu_rst_n_d = 1'b1;
          done_d      = 1'b1;
        end
      end
      LOAD: begin
        if (bus.load_abort) begin
          state_d    = BOOT_WAIT;
          byte_cnt_d = 2'd0;
          shift_d    = '0;
        end else if (accept) begin
          checksum_d = checksum_q ^ bus.byte_data;
          if (byte_cnt_q == 2'd3) begin
            im_we_d    = 1'b1;
            im_wdata_d = {shift_q, bus.byte_data};
            im_waddr_d = words_loaded_q[ADDR_W-1:0];
            byte_cnt_d = 2'd0;
            if (words_loaded_q == (target_q - ONE_WORD))
              state_d = RELEASE;
          end else begin
            shift_d    = {shift_q[15:0], bus.byte_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      RELEASE: begin
        if (bus.load_abort) begin
          state_d = BOOT_WAIT;
        end else begin
          state_d     = RUN;
          cpu_rst_n_d = 1'b1;
          done_d      = 1'b1;
        end
      end
      default: state_d = BOOT_WAIT;
    endcase

    if (start_load) begin
      state_d        = LOAD;
      cpu_rst_n_d    = 1'b0;
      target_d       = (bus.load_len > MAX_WORDS) ? MAX_WORDS : bus.load_len;
      words_loaded_d = '0;
      checksum_d     = '0;
      byte_cnt_d     = 2'd0;
      shift_d        = '0;
      im_waddr_d     = '0;
    end

    busy_d = (state_d == LOAD) || (state_d == RELEASE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= BOOT_WAIT;
      byte_cnt_q     <= 2'd0;
      shift_q        <= '0;
      target_q       <= '0;
      im_we_q        <= 1'b0;
      im_waddr_q     <= '0;
      im_wdata_q     <= '0;
      cpu_rst_n_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      words_loaded_q <= '0;
      checksum_q     <= '0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      shift_q        <= shift_d;
      target_q       <= target_d;
      im_we_q        <= im_we_d;
      im_waddr_q     <= im_waddr_d;
      im_wdata_q     <= im_wdata_d;
      cpu_rst_n_q    <= cpu_rst_n_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      words_loaded_q <= words_loaded_d;
      checksum_q     <= checksum_d;
    end
  end

  assign bus.byte_ready   = byte_ready;
  assign bus.im_we        = im_we_q;
  assign bus.im_waddr     = im_waddr_q;
  assign bus.im_wdata     = im_wdata_q;
  assign bus.cpu_rst_n    = cpu_rst_n_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.words_loaded = words_loaded_q;
  assign bus.checksum     = checksum_q;
endmodule

// File: tb/tb_im_boot_loader.sv
// Scoreboarded bench: expected memory writes are queued by the stimulus and
// consumed by a negedge monitor; state/status outputs are checked inline.
module tb_im_boot_loader;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  im_boot_loader_if #(.ADDR_W(10)) bus ();
  im_boot_loader_if #(.ADDR_W(2))  bus2 ();

  im_boot_loader #(.ADDR_W(10)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  im_boot_loader #(.ADDR_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int checks = 0;
  int errors = 0;

  logic [9:0]  exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [1:0]  exp_addr2_q[$];
  logic [31:0] exp_data2_q[$];
  logic [9:0]  mon_a;
  logic [1:0]  mon_a2;
  logic [31:0] mon_d;
  logic [31:0] mon_d2;

  logic [7:0] prog [8] = '{8'h8C, 8'h01, 8'h00, 8'h01, 8'h00, 8'h22, 8'h18, 8'h20};
  logic [7:0] beef [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

  // Scoreboard monitor for both loaders.
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr %0d data %08h, required no write", bus.im_waddr, bus.im_wdata);
      end else begin
        mon_a = exp_addr_q.pop_front();
        mon_d = exp_data_q.pop_front();
        if (bus.im_waddr !== mon_a || bus.im_wdata !== mon_d) begin
          errors++;
          $display("FAIL wr: got addr %0d data %08h, required addr %0d data %08h",
                   bus.im_waddr, bus.im_wdata, mon_a, mon_d);
        end else begin
          $display("write ok: addr %0d data %08h", bus.im_waddr, bus.im_wdata);
        end
      end
    end
    if (bus2.im_we === 1'b1) begin
      checks++;
      if (exp_addr2_q.size() == 0) begin
        errors++;
        $display("FAIL wr2_unexpected: got addr %0d data %08h, required no write", bus2.im_waddr, bus2.im_wdata);
      end else begin
        mon_a2 = exp_addr2_q.pop_front();
        mon_d2 = exp_data2_q.pop_front();
        if (bus2.im_waddr !== mon_a2 || bus2.im_wdata !== mon_d2) begin
          errors++;
          $display("FAIL wr2: got addr %0d data %08h, required addr %0d data %08h",
                   bus2.im_waddr, bus2.im_wdata, mon_a2, mon_d2);
        end else begin
          $display("write2 ok: addr %0d data %08h", bus2.im_waddr, bus2.im_wdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("check ok: %s = %0h", name, act);
    end
  endtask

  task automatic push_wr(input logic [9:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic start_load(input logic [10:0] len);
    bus.load_start = 1'b1;
    bus.load_len   = len;
    tick();
    bus.load_start = 1'b0;
    bus.load_len   = '0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n;
    n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = d;
    while (bus.byte_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.byte_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got byte_ready=%b, required 1 within 20 cycles", bus.byte_ready);
    end
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_im_we"},        32'(bus.im_we), 32'd0);
    chk({tag, "_im_waddr"},     32'(bus.im_waddr), 32'd0);
    chk({tag, "_im_wdata"},     bus.im_wdata, 32'd0);
    chk({tag, "_cpu_rst_n"},    32'(bus.cpu_rst_n), 32'd0);
    chk({tag, "_busy"},         32'(bus.busy), 32'd0);
    chk({tag, "_done"},         32'(bus.done), 32'd0);
    chk({tag, "_words_loaded"}, 32'(bus.words_loaded), 32'd0);
    chk({tag, "_checksum"},     32'(bus.checksum), 32'd0);
    chk({tag, "_byte_ready"},   32'(bus.byte_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.load_start = 1'b0;  bus.load_len = '0;  bus.load_abort = 1'b0;
    bus.byte_valid = 1'b1;  bus.byte_data = 8'h00;
    bus2.load_start = 1'b0; bus2.load_len = '0; bus2.load_abort = 1'b0;
    bus2.byte_valid = 1'b0; bus2.byte_data = 8'h00;

    // Reset for two cycles, then idle in BOOT_WAIT.
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    bus.byte_valid = 1'b0;
    repeat (3) tick();
    chk("boot_wait_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    chk("boot_wait_busy", 32'(bus.busy), 32'd0);

    // Two-word back-to-back load.
    push_wr(10'd0, 32'h8C010001);
    push_wr(10'd1, 32'h00221820);
    start_load(11'd2);
    chk("load_busy", 32'(bus.busy), 32'd1);
    chk("load_byte_ready", 32'(bus.byte_ready), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(prog[i]);
    chk("release_busy", 32'(bus.busy), 32'd1);
    chk("release_cpu_held", 32'(bus.cpu_rst_n), 32'd0);
    chk("release_byte_ready", 32'(bus.byte_ready), 32'd0);
    tick();
    chk("run_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd1);
    chk("run_done", 32'(bus.done), 32'd1);
    chk("run_words_loaded", 32'(bus.words_loaded), 32'd2);
    chk("run_checksum", 32'(bus.checksum), 32'h96);
    tick();
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("two_word_queue_empty", 32'(exp_addr_q.size()), 32'd0);

    // Same bytes with gaps; reload from RUN re-halts the CPU.
    push_wr(10'd0, 32'h8C010001);
    push_wr(10'd1, 32'h00221820);
    start_load(11'd2);
    chk("reload_cpu_halt", 32'(bus.cpu_rst_n), 32'd0);
    for (int i = 0; i < 8; i++) begin
      send_byte(prog[i]);
      if (i < 7) begin
        int gap;
        gap = int'($urandom_range(1, 3));
        for (int g = 0; g < gap; g++) begin
          chk("gap_byte_ready", 32'(bus.byte_ready), 32'd1);
          tick();
        end
      end
    end
    tick();
    chk("gap_done", 32'(bus.done), 32'd1);
    chk("gap_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd1);
    chk("gap_words_loaded", 32'(bus.words_loaded), 32'd2);
    chk("gap_checksum", 32'(bus.checksum), 32'h96);
    chk("gap_queue_empty", 32'(exp_addr_q.size()), 32'd0);

    // Abort mid-word with a byte on offer in the same cycle.
    push_wr(10'd0, 32'h8C010001);
    start_load(11'd3);
    for (int i = 0; i < 6; i++) send_byte(prog[i]);
    bus.byte_valid = 1'b1;
    bus.byte_data  = prog[6];
    bus.load_abort = 1'b1;
    #1;
    chk("abort_byte_ready", 32'(bus.byte_ready), 32'd0);
    tick();
    bus.load_abort = 1'b0;
    bus.byte_valid = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    chk("abort_words_loaded", 32'(bus.words_loaded), 32'd1);
    chk("abort_checksum", 32'(bus.checksum), 32'hAE);
    repeat (4) tick();
    chk("abort_still_halted", 32'(bus.cpu_rst_n), 32'd0);
    chk("abort_queue_empty", 32'(exp_addr_q.size()), 32'd0);

    // Zero-length load releases the CPU, then a one-word reload.
    start_load(11'd0);
    chk("zero_done", 32'(bus.done), 32'd1);
    chk("zero_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd1);
    chk("zero_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("zero_done_clear", 32'(bus.done), 32'd0);
    push_wr(10'd0, 32'hDEADBEEF);
    start_load(11'd1);
    chk("one_cpu_halt", 32'(bus.cpu_rst_n), 32'd0);
    chk("one_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 4; i++) send_byte(beef[i]);
    tick();
    chk("one_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd1);
    chk("one_done", 32'(bus.done), 32'd1);
    chk("one_words_loaded", 32'(bus.words_loaded), 32'd1);
    chk("one_checksum", 32'(bus.checksum), 32'h22);

    // Reset after five bytes of a two-word load.
    push_wr(10'd0, 32'h8C010001);
    start_load(11'd2);
    for (int i = 0; i < 5; i++) send_byte(prog[i]);
    rst_n = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = prog[5];
    tick();
    check_reset_outputs("midreset");
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("midreset_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("midreset_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    bus.byte_valid = 1'b0;
    chk("midreset_queue_empty", 32'(exp_addr_q.size()), 32'd0);

    // Length clamp on the 4-word instance.
    exp_addr2_q.push_back(2'd0); exp_data2_q.push_back(32'h00112233);
    exp_addr2_q.push_back(2'd1); exp_data2_q.push_back(32'h44556677);
    exp_addr2_q.push_back(2'd2); exp_data2_q.push_back(32'h8899AABB);
    exp_addr2_q.push_back(2'd3); exp_data2_q.push_back(32'hCCDDEEFF);
    bus2.load_start = 1'b1;
    bus2.load_len   = 3'd7;
    tick();
    bus2.load_start = 1'b0;
    bus2.load_len   = '0;
    for (int i = 0; i < 16; i++) begin
      bus2.byte_valid = 1'b1;
      bus2.byte_data  = 8'(i * 17);
      #1;
      if (bus2.byte_ready !== 1'b1) chk("clamp_byte_ready", 32'(bus2.byte_ready), 32'd1);
      tick();
    end
    chk("clamp_extra_byte_refused", 32'(bus2.byte_ready), 32'd0);
    bus2.byte_valid = 1'b0;
    tick();
    chk("clamp_cpu_rst_n", 32'(bus2.cpu_rst_n), 32'd1);
    chk("clamp_done", 32'(bus2.done), 32'd1);
    chk("clamp_words_loaded", 32'(bus2.words_loaded), 32'd4);
    chk("clamp_waddr_no_wrap", 32'(bus2.im_waddr), 32'd3);
    chk("clamp_busy", 32'(bus2.busy), 32'd0);
    repeat (2) tick();
    chk("clamp_queue_empty", 32'(exp_addr2_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/im_boot_loader.md
Name: im_boot_loader

Overview:
Controller that sequences program loading into the single-cycle CPU's instruction memory before and between runs. It receives a byte stream from a host over a valid/ready handshake and assembles big-endian 32-bit words. It drives the memory's write port at incrementing word addresses and holds the CPU in reset until the load completes. Once a load completes it releases the CPU; a later load re-halts it.

Parameters:
ADDR_W, 10, word-index width of instruction memory (2^ADDR_W words; 1024 default)

Ports:
clk  in  1  system clock, all state changes on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising clk edge
load_start  in  1  single-cycle request to begin a load; load_len sampled same cycle
load_len  in  ADDR_W+1  number of 32-bit words to load
load_abort  in  1  cancel current load
byte_valid  in  1  host byte available
byte_data  in  8  host byte
byte_ready  out  1  loader accepts byte this cycle
im_we  out  1  instruction-memory write enable
im_waddr  out  ADDR_W  word index for write
im_wdata  out  32  write data
cpu_rst_n  out  1  active-low reset to CPU core (0 = held)
busy  out  1  high while in LOAD or RELEASE
done  out  1  one-cycle pulse on load completion
words_loaded  out  ADDR_W+1  words written in current/last load
checksum  out  8  XOR of all bytes accepted in current/last load

Behaviour:
- Reset (rst_n=0 at edge): state=BOOT_WAIT.
  - im_we=0, im_waddr=0, im_wdata=0, cpu_rst_n=0, busy=0, done=0, words_loaded=0, checksum=0.
  - Byte counter and word counter cleared.
  - Reset mid-load discards everything; no further writes.
- States: BOOT_WAIT, LOAD, RELEASE, RUN.
- BOOT_WAIT: cpu_rst_n=0, byte_ready=0.
  - load_start with load_len>0 -> LOAD.
  - load_start with load_len==0 -> RUN, with done pulse next cycle.
- RUN: cpu_rst_n=1, byte_ready=0.
  - load_start with load_len>0 -> LOAD; cpu_rst_n drops to 0 at the same edge.
  - load_start with load_len==0 -> done pulse only; CPU stays running.
- Entering LOAD:
  - Latch target = min(load_len, 2^ADDR_W).
  - Clear words_loaded, checksum, byte counter; im_waddr=0.
- LOAD: byte_ready=1 combinationally whenever state==LOAD and load_abort=0.
  - Byte accepted when byte_valid & byte_ready.
  - Byte counter 0..3; byte 0 goes to bits 31:24, byte 3 to bits 7:0.
  - Each accepted byte XORs into checksum.
  - Gaps in byte_valid are allowed; partial-word state is held.
- Word write: on acceptance of byte 3, at that edge:
  - im_we<=1; im_wdata<=assembled word; im_waddr<=current word index.
  - im_we is high for exactly one cycle.
  - words_loaded increments at the edge ending the write cycle; im_waddr then advances.
  - Max one write per 4 accepted bytes; im_waddr never wraps (target clamped).
- Final word: on acceptance of byte 3 of word target-1, state->RELEASE (write still issued).
  - RELEASE: byte_ready=0, busy=1.
  - Next edge: im_we<=0, state->RUN, cpu_rst_n<=1, done<=1 for one cycle.
- load_abort (any cycle in LOAD or RELEASE): next edge state->BOOT_WAIT.
  - im_we<=0; partial word discarded; cpu_rst_n stays 0.
  - words_loaded and checksum keep their current values.
  - Abort has priority over load_start and over byte acceptance in the same cycle.
  - An abort during RELEASE still suppresses the CPU release.
- load_start while in LOAD or RELEASE is ignored.
- busy=1 in LOAD and RELEASE; 0 otherwise.

Test Plan:
- Reset: hold rst_n=0 two cycles -> all outputs 0, byte_ready=0; stays in BOOT_WAIT with cpu_rst_n=0 until load_start.
- Two-word load: load_start, load_len=2, bytes 8C 01 00 01 00 22 18 20 back-to-back ->
  - im_we pulses at addr 0 data 0x8C010001, then at addr 1 data 0x00221820;
  - cpu_rst_n=1 one cycle after the second write cycle; done pulse; words_loaded=2; checksum=0x96.
- Gapped stream: same bytes with byte_valid low 1-3 random cycles between bytes -> identical writes and checksum; byte_ready stays 1 throughout LOAD.
- Abort mid-word: load_len=3, send 6 bytes, assert load_abort with byte_valid high ->
  - exactly one write occurs (addr 0); the abort-cycle byte is not accepted;
  - returns to BOOT_WAIT with cpu_rst_n=0 and words_loaded=1.
- Zero-length and reload: load_len=0 from BOOT_WAIT -> RUN with done, no im_we.
  - Then load_start, load_len=1 from RUN -> cpu_rst_n falls at that edge; after 4 bytes, one write at addr 0 and the CPU is released.
- Reset mid-load / clamp: rst_n=0 after 5 bytes -> no further im_we, all outputs reset.
  - With ADDR_W=2, load_len=7 -> exactly 4 writes (addr 0..3), then RUN.
